// File: rtl/flanger_pkg.sv
// rtl/flanger_pkg.sv - shared types and helpers for the flex_flanger delay/flanger core
//
// Purpose : mode and FSM state enumerations plus a mode decode helper.
// Ports   : none (package).

package flanger_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_FLANGE = 2'b01,
        MODE_ECHO   = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_IDLE  = 2'b01,
        ST_READ  = 2'b10,
        ST_MIX   = 2'b11
    } state_t;

    // Encoding 2'b11 is not a named mode and behaves as bypass.
    function automatic logic is_bypass(input logic [1:0] m);
        return !((m == MODE_FLANGE) || (m == MODE_ECHO));
    endfunction

endpackage

// File: rtl/flanger_lfo.sv
// rtl/flanger_lfo.sv - triangle LFO that sweeps the flanger delay across the delay line
//
// Purpose : counts step requests; every rate+1 requests moves pos one step along a
//           0..DEPTH-1..0 triangle without repeating the endpoints.
// Ports   : clk      system clock
//           n_rst    asynchronous active-low reset
//           step_en  one pulse per accepted sample
//           rate     divider; pos moves every rate+1 step_en pulses
//           pos      current triangle position (delay in samples)

module flanger_lfo #(
    parameter int DEPTH  = 1024,
    parameter int RATE_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              step_en,
    input  logic [RATE_W-1:0] rate,
    output logic [AW-1:0]     pos
);

    logic [RATE_W-1:0] r_rate_cnt;
    logic [AW-1:0]     r_pos;
    logic              r_dir_up;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rate_cnt <= '0;
            r_pos      <= '0;
            r_dir_up   <= 1'b1;
        end else if (step_en) begin
            if (r_rate_cnt == rate) begin
                r_rate_cnt <= '0;
                // Turning at an endpoint moves straight off it, so 0 and DEPTH-1
                // each appear once per sweep.
                if (r_dir_up) begin
                    if (r_pos == AW'(DEPTH - 1)) begin
                        r_dir_up <= 1'b0;
                        r_pos    <= r_pos - AW'(1);
                    end else begin
                        r_pos    <= r_pos + AW'(1);
                    end
                end else begin
                    if (r_pos == '0) begin
                        r_dir_up <= 1'b1;
                        r_pos    <= r_pos + AW'(1);
                    end else begin
                        r_pos    <= r_pos - AW'(1);
                    end
                end
            end else begin
                r_rate_cnt <= r_rate_cnt + RATE_W'(1);
            end
        end
    end

    assign pos = r_pos;

endmodule

// File: rtl/flex_flanger.sv
// rtl/flex_flanger.sv - flanger/echo/bypass core with internal circular delay line
//
// Purpose : one sample in, one sample out over a valid/ready handshake; mixes the
//           input with a delayed copy from an internal delay line.
// Macro   : FLANGER_FEEDBACK_EN - when defined, non-bypass modes store
//           sat(x + (y>>>1)) into the delay line instead of x.
// Ports   : clk        system clock
//           n_rst      asynchronous active-low reset
//           mode       00 bypass, 01 flanger, 10 echo, 11 bypass
//           rate       LFO steps every rate+1 accepted samples
//           delay_cfg  echo-mode delay in samples
//           mem_clr    level request to zero the delay line
//           in_valid   / in_ready / in_data    input sample handshake
//           out_valid  one-cycle pulse with out_data
//           out_data   processed sample, held until the next out_valid

module flex_flanger
    import flanger_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int RATE_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [1:0]        mode,
    input  logic [RATE_W-1:0] rate,
    input  logic [AW-1:0]     delay_cfg,
    input  logic              mem_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [AW-1:0]             r_clr_addr;
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_addr;
    logic signed [DATA_W-1:0]  r_x;
    logic signed [DATA_W-1:0]  r_y;
    logic [1:0]                r_mode;
    logic [RATE_W-1:0]         r_rate;
    logic signed [DATA_W-1:0]  r_mix;
    logic                      r_out_pend;
    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_out_data;
    logic                      r_clr_req;
    logic [DATA_W-1:0]         r_mem [DEPTH];

    logic                      w_in_ready;
    logic                      w_accept;
    logic [AW-1:0]             w_lfo_pos;
    logic [AW-1:0]             w_delay;
    logic signed [DATA_W:0]    w_sum;
    logic signed [DATA_W-1:0]  w_avg;
    logic signed [DATA_W-1:0]  w_out;
    logic signed [DATA_W-1:0]  w_store;
    logic                      w_mem_we;
    logic [AW-1:0]             w_mem_waddr;
    logic [DATA_W-1:0]         w_mem_wdata;

    // The result is parked for one cycle in r_mix so out_data only changes
    // together with out_valid; in_ready stays low until that pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_addr == AW'(DEPTH - 1)) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                w_in_ready = !r_out_pend;
                if (in_valid && w_in_ready)   w_state_nxt = ST_READ;
                else if (mem_clr || r_clr_req) w_state_nxt = ST_CLEAR;
            end
            ST_READ:  w_state_nxt = ST_MIX;
            ST_MIX:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    assign in_ready  = w_in_ready;
    assign w_accept  = in_valid && w_in_ready;
    assign w_delay   = (mode == MODE_FLANGE) ? w_lfo_pos : delay_cfg;

    // Averaging at DATA_W+1 bits cannot overflow.
    assign w_sum = (DATA_W+1)'(r_x) + (DATA_W+1)'(r_y);
    assign w_avg = DATA_W'(w_sum >>> 1);
    assign w_out = is_bypass(r_mode) ? r_x : w_avg;

`ifdef FLANGER_FEEDBACK_EN
    localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
    logic signed [DATA_W:0]   w_fb;
    logic signed [DATA_W-1:0] w_fb_sat;

    assign w_fb = (DATA_W+1)'(r_x) + (DATA_W+1)'(r_y >>> 1);

    always_comb begin
        w_fb_sat = w_fb[DATA_W-1:0];
        if (w_fb[DATA_W] != w_fb[DATA_W-1]) w_fb_sat = w_fb[DATA_W] ? SMIN : SMAX;
    end

    assign w_store = is_bypass(r_mode) ? r_x : w_fb_sat;
`else
    assign w_store = r_x;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= ST_CLEAR;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_clr_addr  <= '0;
            r_wr_ptr    <= '0;
            r_rd_addr   <= '0;
            r_x         <= '0;
            r_mode      <= '0;
            r_rate      <= '0;
            r_mix       <= '0;
            r_out_pend  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_clr_req   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_clr_addr  <= (r_state == ST_CLEAR) ? r_clr_addr + AW'(1) : '0;

            if (w_accept) begin
                r_x       <= in_data;
                r_mode    <= mode;
                r_rate    <= rate;
                r_rd_addr <= r_wr_ptr - AW'(1) - w_delay;
            end

            if (r_state == ST_MIX) begin
                r_mix      <= w_out;
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                r_out_pend <= 1'b1;
            end else if (r_out_pend) begin
                r_out_pend  <= 1'b0;
                r_out_valid <= 1'b1;
                r_out_data  <= r_mix;
            end

            // A clear request seen mid-sample is remembered so a short pulse
            // still clears once the sample has left the pipeline.
            if (r_state == ST_CLEAR)
                r_clr_req <= 1'b0;
            else if (mem_clr && (r_state == ST_READ || r_state == ST_MIX))
                r_clr_req <= 1'b1;
        end
    end

    assign w_mem_we    = (r_state == ST_CLEAR) || (r_state == ST_MIX);
    assign w_mem_waddr = (r_state == ST_CLEAR) ? r_clr_addr : r_wr_ptr;
    assign w_mem_wdata = (r_state == ST_CLEAR) ? '0 : w_store;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
        if (r_state == ST_READ) r_y <= r_mem[r_rd_addr];
    end

    flanger_lfo #(
        .DEPTH  (DEPTH),
        .RATE_W (RATE_W)
    ) u_lfo (
        .clk     (clk),
        .n_rst   (n_rst),
        .step_en (r_state == ST_MIX),
        .rate    (r_rate),
        .pos     (w_lfo_pos)
    );

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
